centi_to_calendar: RTL and testbench

CENTI_TO_CALENDAR -- requirements
Module: centi_to_calendar

---
 rtl/timer_pkg.sv | 26 ++
 rtl/serial_divider.sv | 69 ++++++
 rtl/centi_to_calendar.sv | 135 +++++++++++++
 tb/tb_centi_to_calendar.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants, field widths and FSM encoding for the centisecond calendar converter.
package timer_pkg;

    localparam int unsigned DIV_W = 64;

    localparam int unsigned DAY_W = 41;
    localparam int unsigned HR_W  = 5;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned CS_W  = 7;

    localparam int unsigned CS_PER_DAY  = 8640000;
    localparam int unsigned CS_PER_HOUR = 360000;
    localparam int unsigned CS_PER_MIN  = 6000;
    localparam int unsigned CS_PER_SEC  = 100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIV_DAY = 3'd1,
        DIV_HR  = 3'd2,
        DIV_MIN = 3'd3,
        DIV_SEC = 3'd4,
        DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider: one load cycle on i_start, then one quotient bit per cycle.
// o_done_c marks the cycle whose clock edge completes the last iteration; the
// *_nxt_c outputs carry the values that edge will register.
module serial_divider
    import timer_pkg::*;
#(
    parameter int unsigned W = DIV_W
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done_c,
    output logic [W-1:0] o_remainder,
    output logic [W-1:0] o_quo_nxt_c,
    output logic [W-1:0] o_rem_nxt_c
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [W:0]       w_shift;
    logic [W:0]       w_div_ext;
    logic             w_ge;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        w_shift     = {r_rem, r_quo[W-1]};
        w_div_ext   = {1'b0, r_div};
        w_ge        = (w_shift >= w_div_ext);
        o_rem_nxt_c = w_ge ? W'(w_shift - w_div_ext) : W'(w_shift);
        o_quo_nxt_c = {r_quo[W-2:0], w_ge};
        o_done_c    = r_busy && (r_cnt == CNT_W'(1));
    end

    // Divider state: load on start, iterate W times while busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= CNT_W'(W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= o_rem_nxt_c;
            r_quo  <= o_quo_nxt_c;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= (r_cnt != CNT_W'(1));
        end
    end

    assign o_busy      = r_busy;
    assign o_remainder = r_rem;

endmodule

// File: rtl/centi_to_calendar.sv
// Converts an elapsed centisecond count into days / hh:mm:ss.cc with one shared serial divider.
module centi_to_calendar
    import timer_pkg::*;
#(
    parameter int unsigned COUNT_W = 64
)
(
    input  logic               clockSignal,
    input  logic               reset,
    input  logic [COUNT_W-1:0] countIn,
    input  logic               inValid,
    output logic               inReady,
    output logic [DAY_W-1:0]   dayCount,
    output logic [HR_W-1:0]    hoursOut,
    output logic [MIN_W-1:0]   minutesOut,
    output logic [SEC_W-1:0]   secondsOut,
    output logic [CS_W-1:0]    centisOut,
    output logic               outValid,
    input  logic               outReady
);

    state_e             r_state;
    state_e             w_next_state;

    logic [COUNT_W-1:0] r_count;
    logic [DAY_W-1:0]   r_day;
    logic [HR_W-1:0]    r_hr;
    logic [MIN_W-1:0]   r_min;

    logic               w_start;
    logic               w_busy;
    logic               w_done;
    logic [DIV_W-1:0]   w_dividend;
    logic [DIV_W-1:0]   w_divisor;
    logic [DIV_W-1:0]   w_rem;
    logic [DIV_W-1:0]   w_quo_nxt;
    logic [DIV_W-1:0]   w_rem_nxt;

    serial_divider #(.W(DIV_W)) u_div (
        .i_clk       (clockSignal),
        .i_rst       (reset),
        .i_start     (w_start),
        .i_dividend  (w_dividend),
        .i_divisor   (w_divisor),
        .o_busy      (w_busy),
        .o_done_c    (w_done),
        .o_remainder (w_rem),
        .o_quo_nxt_c (w_quo_nxt),
        .o_rem_nxt_c (w_rem_nxt)
    );

    // Next-state and divider operand selection; each stage starts the divider in its first cycle.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_dividend   = w_rem;
        w_divisor    = DIV_W'(CS_PER_DAY);
        unique case (r_state)
            IDLE: begin
                if (inValid && inReady) w_next_state = DIV_DAY;
            end
            DIV_DAY: begin
                w_start    = !w_busy;
                w_dividend = DIV_W'(r_count);
                w_divisor  = DIV_W'(CS_PER_DAY);
                if (w_done) w_next_state = DIV_HR;
            end
            DIV_HR: begin
                w_start   = !w_busy;
                w_divisor = DIV_W'(CS_PER_HOUR);
                if (w_done) w_next_state = DIV_MIN;
            end
            DIV_MIN: begin
                w_start   = !w_busy;
                w_divisor = DIV_W'(CS_PER_MIN);
                if (w_done) w_next_state = DIV_SEC;
            end
            DIV_SEC: begin
                w_start   = !w_busy;
                w_divisor = DIV_W'(CS_PER_SEC);
                if (w_done) w_next_state = DONE;
            end
            DONE: begin
                if (outReady) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and registered handshake flags derived from the next state.
    always_ff @(posedge clockSignal) begin
        if (reset) begin
            r_state  <= IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            inReady  <= (w_next_state == IDLE);
            outValid <= (w_next_state == DONE);
        end
    end

    // Capture the accepted count, stage each quotient, publish all fields on DONE entry.
    always_ff @(posedge clockSignal) begin
        if (reset) begin
            r_count    <= '0;
            r_day      <= '0;
            r_hr       <= '0;
            r_min      <= '0;
            dayCount   <= '0;
            hoursOut   <= '0;
            minutesOut <= '0;
            secondsOut <= '0;
            centisOut  <= '0;
        end else begin
            if ((r_state == IDLE) && inValid && inReady) r_count <= countIn;
            if (w_done) begin
                case (r_state)
                    DIV_DAY: r_day <= DAY_W'(w_quo_nxt);
                    DIV_HR:  r_hr  <= HR_W'(w_quo_nxt);
                    DIV_MIN: r_min <= MIN_W'(w_quo_nxt);
                    DIV_SEC: begin
                        dayCount   <= r_day;
                        hoursOut   <= r_hr;
                        minutesOut <= r_min;
                        secondsOut <= SEC_W'(w_quo_nxt);
                        centisOut  <= CS_W'(w_rem_nxt);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_centi_to_calendar.sv
// Self-checking bench for centi_to_calendar: vector table, scoreboard queue, backpressure and reset sequences.
module tb_centi_to_calendar;

    typedef struct {
        logic [63:0] count;
        logic [40:0] day;
        logic [4:0]  hr;
        logic [5:0]  mn;
        logic [5:0]  sec;
        logic [6:0]  cs;
    } vec_t;

    logic        clockSignal = 1'b0;
    logic        reset       = 1'b1;
    logic [63:0] countIn     = '0;
    logic        inValid     = 1'b0;
    logic        inReady;
    logic [40:0] dayCount;
    logic [4:0]  hoursOut;
    logic [5:0]  minutesOut;
    logic [5:0]  secondsOut;
    logic [6:0]  centisOut;
    logic        outValid;
    logic        outReady    = 1'b1;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    vec_t sb[$];
    vec_t last;
    vec_t tbl[7];

    centi_to_calendar #(.COUNT_W(64)) dut (
        .clockSignal (clockSignal),
        .reset       (reset),
        .countIn     (countIn),
        .inValid     (inValid),
        .inReady     (inReady),
        .dayCount    (dayCount),
        .hoursOut    (hoursOut),
        .minutesOut  (minutesOut),
        .secondsOut  (secondsOut),
        .centisOut   (centisOut),
        .outValid    (outValid),
        .outReady    (outReady)
    );

    always #5 clockSignal = ~clockSignal;

    always @(posedge clockSignal) cyc <= cyc + 1;

    function automatic vec_t model(input logic [63:0] c);
        vec_t        v;
        logic [63:0] r;
        v.count = c;
        v.day   = 41'(c / 64'd8640000);
        r       = c % 64'd8640000;
        v.hr    = 5'(r / 64'd360000);
        r       = r % 64'd360000;
        v.mn    = 6'(r / 64'd6000);
        r       = r % 64'd6000;
        v.sec   = 6'(r / 64'd100);
        v.cs    = 7'(r % 64'd100);
        return v;
    endfunction

    task automatic tick();
        @(posedge clockSignal);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_fields(input string tag, input vec_t e);
        check({tag, " day"}, 64'(dayCount),   64'(e.day));
        check({tag, " hr"},  64'(hoursOut),   64'(e.hr));
        check({tag, " min"}, 64'(minutesOut), 64'(e.mn));
        check({tag, " sec"}, 64'(secondsOut), 64'(e.sec));
        check({tag, " cs"},  64'(centisOut),  64'(e.cs));
    endtask

    // Drive one count, follow it to DONE, compare against the scoreboard; hold>0 applies backpressure.
    task automatic run_vec(input vec_t v, input string tag, input int hold);
        int   guard;
        int   acc;
        vec_t e;
        guard = 0;
        while (!inReady && guard < 400) begin
            tick();
            guard++;
        end
        check({tag, " in_ready"}, 64'(inReady), 64'd1);
        outReady = (hold == 0);
        countIn  = v.count;
        inValid  = 1'b1;
        tick();
        acc = cyc;
        sb.push_back(v);
        inValid = 1'b0;
        countIn = '0;
        guard   = 0;
        while (!outValid && guard < 400) begin
            tick();
            guard++;
            if (guard == 130) begin
                check({tag, " mid day"}, 64'(dayCount),  64'(last.day));
                check({tag, " mid cs"},  64'(centisOut), 64'(last.cs));
            end
        end
        check({tag, " latency"}, 64'(cyc - acc), 64'd260);
        check({tag, " out_valid"}, 64'(outValid), 64'd1);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard: got empty queue expected 1 entry", tag);
            e = v;
        end else begin
            e = sb.pop_front();
        end
        check_fields(tag, e);
        check({tag, " in_ready done"}, 64'(inReady), 64'd0);
        last = e;
        for (int i = 0; i < hold; i++) begin
            countIn = {$urandom(), $urandom()};
            inValid = i[0];
            tick();
            check({tag, " hold valid"}, 64'(outValid), 64'd1);
            check({tag, " hold ready"}, 64'(inReady),  64'd0);
            check_fields({tag, " hold"}, e);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        tick();
        check({tag, " valid drop"}, 64'(outValid), 64'd0);
        check({tag, " idle ready"}, 64'(inReady),  64'd1);
    endtask

    initial begin
        int nv;
        tbl[0] = '{64'd0,                      41'd0,             5'd0,  6'd0,  6'd0,  7'd0};
        tbl[1] = '{64'd8639999,                41'd0,             5'd23, 6'd59, 6'd59, 7'd99};
        tbl[2] = '{64'd8640000,                41'd1,             5'd0,  6'd0,  6'd0,  7'd0};
        tbl[3] = '{64'd3723456,                41'd0,             5'd10, 6'd20, 6'd34, 7'd56};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF,    41'd2135039823346, 5'd0,  6'd18, 6'd36, 7'd15};
        tbl[5] = '{64'd9006101,                41'd1,             5'd1,  6'd1,  6'd1,  7'd1};
        tbl[6] = '{64'd100,                    41'd0,             5'd0,  6'd0,  6'd1,  7'd0};
        last   = model(64'd0);

        repeat (3) tick();
        check("reset in_ready",  64'(inReady),  64'd1);
        check("reset out_valid", 64'(outValid), 64'd0);
        check_fields("reset", last);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 0);

        for (int i = 0; i < 3; i++) run_vec(model({$urandom(), $urandom()}), $sformatf("rnd%0d", i), 0);
        run_vec(model(64'($urandom_range(0, 100000000))), "rnd_small", 0);

        run_vec(model(64'd987654321), "backpressure", 20);

        // Abort a conversion with reset 100 cycles after it was accepted.
        countIn = 64'd123456789;
        inValid = 1'b1;
        tick();
        sb.push_back(model(64'd123456789));
        inValid = 1'b0;
        repeat (99) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        last = model(64'd0);
        check("abort out_valid", 64'(outValid), 64'd0);
        check("abort in_ready",  64'(inReady),  64'd1);
        check_fields("abort", last);
        nv = 0;
        repeat (300) begin
            tick();
            if (outValid) nv++;
        end
        check("abort no pulse", 64'(nv), 64'd0);
        run_vec(tbl[6], "after_abort", 0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
